// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths and default sizing for the float stream packer
package fp_pkg;

  localparam int FP_W             = 32;
  localparam int DEF_CONV_LATENCY = 8;
  localparam int DEF_FIFO_DEPTH   = 16;
  localparam int DEF_FRAME_LEN    = 256;

  // Frame counter width; a two-sample frame still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// rtl/fp_sync_fifo.sv - first-word-fall-through FIFO with occupancy level
module fp_sync_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int W     = FP_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fp_stream_packer.sv
// rtl/fp_stream_packer.sv - aligns converter results with in_valid, buffers them and frames the output stream
module fp_stream_packer
  import fp_pkg::*;
#(
  parameter int CONV_LATENCY = DEF_CONV_LATENCY,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int FRAME_LEN    = DEF_FRAME_LEN
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  input  logic                        in_valid,
  input  logic [FP_W-1:0]             fp_data,
  output logic [FP_W-1:0]             m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clear_ovf
);

  localparam int CNT_W = cnt_width(FRAME_LEN);

  logic [CONV_LATENCY-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic                    overflow_q, overflow_d;
  logic                    dvalid, fifo_full, fifo_empty;
  logic                    push, pop, drop, at_last;

  assign dvalid  = shift_q[CONV_LATENCY-1];
  assign pop     = !fifo_empty && m_axis_tready;
  assign push    = dvalid && (!fifo_full || pop);
  assign drop    = dvalid && fifo_full && !pop;
  assign at_last = (frame_cnt_q == CNT_W'(FRAME_LEN - 1));

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tlast  = !fifo_empty && at_last;
  assign overflow      = overflow_q;

  always_comb begin
    shift_d[0] = in_valid;
    for (int i = 1; i < CONV_LATENCY; i++) shift_d[i] = shift_q[i-1];

    frame_cnt_d = frame_cnt_q;
    if (pop) frame_cnt_d = at_last ? '0 : frame_cnt_q + CNT_W'(1);

    // A drop in the clearing cycle wins so that lost data is never hidden.
    overflow_d = overflow_q;
    if (drop)           overflow_d = 1'b1;
    else if (clear_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      shift_q     <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  fp_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FP_W)
  ) u_fifo (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .push  (push),
    .pop   (pop),
    .wdata (fp_data),
    .rdata (m_axis_tdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fp_stream_packer.sv
// tb/tb_fp_stream_packer.sv - directed and randomized stimulus against a queue-based reference model
module tb_fp_stream_packer;
  import fp_pkg::*;

  localparam int L  = 8;
  localparam int D  = 16;
  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        tready = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] fp_data = '0;
  logic [31:0] tdata;
  logic        tvalid, tlast, ovf;
  logic [4:0]  level;

  int checks = 0;
  int failures = 0;

  logic [31:0] mq[$];
  bit          pipe[$];
  int          fcnt;
  bit          movf;
  bit          will_drop;

  always #5 clk = ~clk;

  fp_stream_packer #(
    .CONV_LATENCY (L),
    .FIFO_DEPTH   (D),
    .FRAME_LEN    (FL)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .in_valid      (in_valid),
    .fp_data       (fp_data),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .fifo_level    (level),
    .overflow      (ovf),
    .clear_ovf     (clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    mq.delete();
    pipe.delete();
    for (int i = 0; i < L; i++) pipe.push_back(1'b0);
    fcnt = 0;
    movf = 1'b0;
  endtask

  // One clock cycle: drive, compare outputs with the model, then advance the model across the edge.
  task automatic cyc(input bit iv, input logic [31:0] d, input bit rdy, input bit c);
    bit dv, full, pop, drop;
    in_valid = iv;
    fp_data  = d;
    tready   = rdy;
    clr      = c;
    #1;
    chk("tvalid", 32'(tvalid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("tdata", tdata, mq[0]);
    chk("tlast", 32'(tlast), 32'((mq.size() != 0) && (fcnt == FL - 1)));
    chk("level", 32'(level), 32'(mq.size()));
    chk("overflow", 32'(ovf), 32'(movf));
    dv   = pipe[0];
    full = (mq.size() == D);
    pop  = (mq.size() != 0) && rdy;
    drop = dv && full && !pop;
    if (pop) begin
      void'(mq.pop_front());
      fcnt = (fcnt + 1) % FL;
    end
    if (dv && !drop) mq.push_back(d);
    if (drop) movf = 1'b1;
    else if (c) movf = 1'b0;
    void'(pipe.pop_front());
    pipe.push_back(iv);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_overflow", 32'(ovf), 32'd0);
    model_reset();
    in_valid = 1'b0;
    tready   = 1'b0;
    clr      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single sample: float arrives L cycles later, appears on the stream one cycle after that.
    cyc(1'b1, 32'h3F80_0000, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 32'h3F80_0000, 1'b1, 1'b0);

    // Saturation with a stalled sink, then an in-order drain.
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, $urandom, 1'b0, 1'b0);
    chk("sat_level", 32'(level), 32'd16);
    chk("sat_overflow", 32'(ovf), 32'd1);
    for (int i = 0; i < 20; i++) cyc(1'b0, $urandom, 1'b1, 1'b0);
    chk("drained_level", 32'(level), 32'd0);

    // Full FIFO with simultaneous pop and arrival never drops.
    do_reset();
    for (int i = 0; i < 24; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, $urandom, 1'b1, 1'b0);
    chk("full_pp_level", 32'(level), 32'd16);
    chk("full_pp_overflow", 32'(ovf), 32'd0);
    for (int i = 0; i < 30; i++) cyc(1'b0, $urandom, 1'b1, 1'b0);

    // Framing: nine samples, tlast on beats four and eight.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, $urandom, 1'b1, 1'b0);

    // Clear coincident with a drop keeps the flag; a later clear releases it.
    do_reset();
    for (int i = 0; i < 18; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      will_drop = pipe[0] && (mq.size() == D);
      cyc(1'b0, $urandom, 1'b0, will_drop);
    end
    chk("ovf_held", 32'(ovf), 32'd1);
    cyc(1'b0, $urandom, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(ovf), 32'd0);
    cyc(1'b0, $urandom, 1'b0, 1'b0);

    // Reset mid-operation with five buffered and three in flight.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd5);
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b0, $urandom, 1'b1, 1'b0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
          $urandom_range(0, 15) == 0);
    for (int i = 0; i < 30; i++) cyc(1'b0, $urandom, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_stream_packer.md
FP_STREAM_PACKER -- requirements
Module: fp_stream_packer

Interface
REQ-001 SHALL have parameter CONV_LATENCY, default 8: cycles from an int sample entering the converter bank to its float on fp_data (range 1..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: output FIFO entries (power of two, 4..64).
REQ-003 SHALL have parameter FRAME_LEN, default 256: samples per output frame (2..65536).
REQ-004 SHALL have port s_axi_aclk, input, 1: the single clock, rising edge.
REQ-005 SHALL have port s_axi_aresetn, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid, input, 1: int_data presented to the converter bank this cycle is a real sample.
REQ-007 SHALL have port fp_data, input, 32: float result from the converter bank mux.
REQ-008 SHALL have port m_axis_tdata, output, 32: output float sample.
REQ-009 SHALL have port m_axis_tvalid, output, 1: tdata holds a sample.
REQ-010 SHALL have port m_axis_tready, input, 1: downstream accepts.
REQ-011 SHALL have port m_axis_tlast, output, 1: last sample of a frame.
REQ-012 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1: current occupancy.
REQ-013 SHALL have port overflow, output, 1: sticky flag, a sample was dropped.
REQ-014 SHALL have port clear_ovf, input, 1: single-cycle clear of overflow.

Function
REQ-015 SHALL delay in_valid through a CONV_LATENCY-stage shift register; stage output dvalid marks fp_data as valid in that cycle.
REQ-016 SHALL push fp_data into the FIFO in the cycle dvalid=1 when FIFO not full, or when full and a pop occurs the same cycle.
REQ-017 SHALL drop the sample and set overflow when dvalid=1, FIFO full, and no same-cycle pop; level and pointers unchanged.
REQ-018 SHALL be first-word-fall-through: m_axis_tvalid = (level != 0), m_axis_tdata = head entry, no added latency.
REQ-019 SHALL pop when m_axis_tvalid and m_axis_tready are both 1; tdata/tlast held stable while tvalid=1 and tready=0.
REQ-020 SHALL update level by +1 on push-only, -1 on pop-only, 0 on push+pop or neither; never exceeds FIFO_DEPTH or goes below 0.
REQ-021 SHALL wrap read/write pointers modulo FIFO_DEPTH.
REQ-022 SHALL keep a frame counter of popped samples, 0..FRAME_LEN-1; m_axis_tlast = tvalid and counter == FRAME_LEN-1; counter wraps to 0 on that pop.
REQ-023 SHALL NOT count dropped samples toward the frame.
REQ-024 SHALL clear overflow on clear_ovf=1 unless a drop occurs the same cycle, in which case overflow stays 1.
REQ-025 SHALL minimum latency in_valid -> m_axis_tvalid = CONV_LATENCY+1 cycles (shift register plus FIFO write).

Reset
REQ-026 SHALL on s_axi_aresetn=0 immediately clear: shift register, pointers, level (fifo_level=0), frame counter, overflow=0, m_axis_tvalid=0, m_axis_tlast=0.
REQ-027 SHALL discard in-flight dvalid samples and FIFO contents on reset mid-operation; FIFO RAM contents need no reset.
REQ-028 SHALL resume normal operation on the first rising edge after deassertion.

Structure
REQ-029 SHALL place FP_W=32 and default CONV_LATENCY/FIFO_DEPTH/FRAME_LEN constants in shared package fp_pkg.
REQ-030 SHALL implement the FIFO as sub-module fp_sync_fifo (storage, pointers, level, full/empty); delay line, drop logic, frame counter, overflow in the top.

Verification
REQ-031 SHALL cover: in_valid=1 single cycle at t0, fp_data=0x3F800000 at t0+8, tready=1 -> tvalid=1 tdata=0x3F800000 at t0+9, one beat.
REQ-032 SHALL cover: tready=0, 20 consecutive in_valid -> fifo_level saturates at 16, overflow=1 after 17th delayed sample, then tready=1 drains exactly 16 in order.
REQ-033 SHALL cover: FIFO full, tready=1 and dvalid=1 same cycle -> no drop, level stays 16, overflow stays 0.
REQ-034 SHALL cover: FRAME_LEN=4, 9 samples streamed with tready=1 -> tlast on beats 4 and 8 only, counter at 1 after beat 9.
REQ-035 SHALL cover: clear_ovf=1 coincident with a drop -> overflow remains 1; clear_ovf next cycle with no drop -> overflow=0.
REQ-036 SHALL cover: s_axi_aresetn low for 1 cycle with FIFO level 5 and 3 samples in delay line -> level=0, tvalid=0 immediately, no stale samples emitted afterward.
